// File: rtl/wishbone_2mst_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// The WB_ARB_TIMEOUT_EN build option is consumed by the top and the watchdog.
package wishbone_2mst_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } arb_state_e;

  localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEADBEEF;

  // One-hot grant vector that mirrors an arbiter state.
  function automatic logic [1:0] grant_of(input arb_state_e st);
    logic [1:0] g;
    case (st)
      GNT_M0:  g = 2'b01;
      GNT_M1:  g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wishbone_2mst_arbiter_if.sv
// Classic Wishbone B4 bus bundle; dat_w flows master->slave, dat_r slave->master.
// Used for both master-side ports and the shared slave port of the arbiter.
interface wishbone_2mst_arbiter_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic [31:0] dat_r;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack
  );
endinterface

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog for the arbiter: per-access wait counter plus saturating event count.
// Only compiled when WB_ARB_TIMEOUT_EN is defined.
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       stb,
  input  logic       ack,
  output logic       fire,
  output logic [7:0] event_cnt
);
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_r;
  logic [7:0]  event_r;

  // Forced termination on the last allowed wait cycle unless the slave answers now.
  always_comb begin
    fire = stb & ~ack & (wait_r == LIMIT);
  end

  // Wait counter restarts whenever the grant is released or the access resolves.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_r <= 16'd0;
    end else if (!hold || ack || !stb || fire) begin
      wait_r <= 16'd0;
    end else begin
      wait_r <= wait_r + 16'd1;
    end
  end

  // Saturating count of forced terminations.
  always_ff @(posedge clk) begin
    if (rst) begin
      event_r <= 8'd0;
    end else if (fire && (event_r != 8'hFF)) begin
      event_r <= event_r + 8'd1;
    end else begin
      event_r <= event_r;
    end
  end

  assign event_cnt = event_r;
endmodule
`endif

// File: rtl/wishbone_2mst_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port between two masters.
// Define WB_ARB_TIMEOUT_EN to add the stalled-slave watchdog (wb_arb_watchdog).
module wishbone_2mst_arbiter
  import wishbone_2mst_arbiter_pkg::*;
#(
`ifdef WB_ARB_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 255,
`endif
  parameter logic [31:0] TIMEOUT_DATA = TIMEOUT_DATA_DEFAULT
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  wishbone_2mst_arbiter_if.slave         m0,
  wishbone_2mst_arbiter_if.slave         m1,
  wishbone_2mst_arbiter_if.master        s,
  output logic [1:0]                     grant_o,
  output logic [7:0]                     timeout_cnt_o
);
  arb_state_e state_r;
  logic       last_gnt_r;
  logic [1:0] grant_r;
  logic       fire_s;

  // Grant FSM: grant is held for the whole CYC burst, ties go to the master not served last.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r    <= IDLE;
      last_gnt_r <= 1'b1;
      grant_r    <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (m0.cyc && (!m1.cyc || last_gnt_r)) begin
            state_r    <= GNT_M0;
            grant_r    <= grant_of(GNT_M0);
            last_gnt_r <= 1'b0;
          end else if (m1.cyc) begin
            state_r    <= GNT_M1;
            grant_r    <= grant_of(GNT_M1);
            last_gnt_r <= 1'b1;
          end else begin
            state_r    <= IDLE;
            grant_r    <= grant_of(IDLE);
            last_gnt_r <= last_gnt_r;
          end
        end
        GNT_M0: begin
          if (!m0.cyc && m1.cyc) begin
            state_r    <= GNT_M1;
            grant_r    <= grant_of(GNT_M1);
            last_gnt_r <= 1'b1;
          end else if (!m0.cyc) begin
            state_r    <= IDLE;
            grant_r    <= grant_of(IDLE);
            last_gnt_r <= last_gnt_r;
          end else begin
            state_r    <= GNT_M0;
            grant_r    <= grant_of(GNT_M0);
            last_gnt_r <= last_gnt_r;
          end
        end
        GNT_M1: begin
          if (!m1.cyc && m0.cyc) begin
            state_r    <= GNT_M0;
            grant_r    <= grant_of(GNT_M0);
            last_gnt_r <= 1'b0;
          end else if (!m1.cyc) begin
            state_r    <= IDLE;
            grant_r    <= grant_of(IDLE);
            last_gnt_r <= last_gnt_r;
          end else begin
            state_r    <= GNT_M1;
            grant_r    <= grant_of(GNT_M1);
            last_gnt_r <= last_gnt_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          grant_r    <= 2'b00;
          last_gnt_r <= 1'b1;
        end
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic gcyc_s;
  logic gstb_s;

  // Cycle/strobe of whichever master currently owns the slave port.
  always_comb begin
    gcyc_s = 1'b0;
    gstb_s = 1'b0;
    case (state_r)
      GNT_M0:  begin gcyc_s = m0.cyc; gstb_s = m0.stb; end
      GNT_M1:  begin gcyc_s = m1.cyc; gstb_s = m1.stb; end
      default: begin gcyc_s = 1'b0;   gstb_s = 1'b0;   end
    endcase
  end

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .hold      (gcyc_s),
    .stb       (gstb_s),
    .ack       (s.ack),
    .fire      (fire_s),
    .event_cnt (timeout_cnt_o)
  );
`else
  assign fire_s        = 1'b0;
  assign timeout_cnt_o = 8'd0;
`endif

  // Combinational datapath steered by the registered grant; a forced termination
  // hides the access from the slave and answers the master with TIMEOUT_DATA.
  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.adr    = 32'd0;
    s.dat_w  = 32'd0;
    s.sel    = 4'd0;
    m0.ack   = 1'b0;
    m0.dat_r = 32'd0;
    m1.ack   = 1'b0;
    m1.dat_r = 32'd0;
    case (state_r)
      GNT_M0: begin
        s.cyc    = m0.cyc & ~fire_s;
        s.stb    = m0.stb & ~fire_s;
        s.we     = m0.we;
        s.adr    = m0.adr;
        s.dat_w  = m0.dat_w;
        s.sel    = m0.sel;
        m0.ack   = s.ack | fire_s;
        m0.dat_r = fire_s ? TIMEOUT_DATA : s.dat_r;
      end
      GNT_M1: begin
        s.cyc    = m1.cyc & ~fire_s;
        s.stb    = m1.stb & ~fire_s;
        s.we     = m1.we;
        s.adr    = m1.adr;
        s.dat_w  = m1.dat_w;
        s.sel    = m1.sel;
        m1.ack   = s.ack | fire_s;
        m1.dat_r = fire_s ? TIMEOUT_DATA : s.dat_r;
      end
      default: begin
        s.cyc  = 1'b0;
        m0.ack = 1'b0;
        m1.ack = 1'b0;
      end
    endcase
  end

  assign grant_o = grant_r;
endmodule

// File: tb/tb_wishbone_2mst_arbiter.sv
// Directed self-checking bench for wishbone_2mst_arbiter; the watchdog steps
// run only when WB_ARB_TIMEOUT_EN is defined (with TIMEOUT_CYCLES=8).
module tb_wishbone_2mst_arbiter;
  import wishbone_2mst_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic [7:0] tcnt;
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  wishbone_2mst_arbiter_if m0_if ();
  wishbone_2mst_arbiter_if m1_if ();
  wishbone_2mst_arbiter_if s_if ();

`ifdef WB_ARB_TIMEOUT_EN
  wishbone_2mst_arbiter #(.TIMEOUT_CYCLES(8)) dut (
`else
  wishbone_2mst_arbiter dut (
`endif
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .m0            (m0_if),
    .m1            (m1_if),
    .s             (s_if),
    .grant_o       (grant),
    .timeout_cnt_o (tcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic m0_drive(input logic cyc, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    m0_if.cyc = cyc; m0_if.stb = cyc; m0_if.we = we;
    m0_if.adr = adr; m0_if.dat_w = dat; m0_if.sel = sel;
  endtask

  task automatic m1_drive(input logic cyc, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    m1_if.cyc = cyc; m1_if.stb = cyc; m1_if.we = we;
    m1_if.adr = adr; m1_if.dat_w = dat; m1_if.sel = sel;
  endtask

  initial begin
    #100000;
    $display("FAIL bench_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    m0_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    m1_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    s_if.ack = 1'b1;
    s_if.dat_r = 32'hFFFF_FFFF;
    step(); step();
    sample();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tcnt", 32'(tcnt), 32'd0);
    check("rst_s_cyc", 32'(s_if.cyc), 32'd0);
    check("rst_s_stb", 32'(s_if.stb), 32'd0);
    check("rst_m0_ack", 32'(m0_if.ack), 32'd0);
    check("rst_m0_dat", m0_if.dat_r, 32'd0);
    check("rst_m1_ack", 32'(m1_if.ack), 32'd0);
    check("rst_m1_dat", m1_if.dat_r, 32'd0);

    // single m0 write, slave acks in the third strobe cycle
    step();
    rst = 1'b0; s_if.ack = 1'b0; s_if.dat_r = 32'd0;
    m0_drive(1'b1, 1'b1, 32'h3001_0004, 32'h1234_5678, 4'hF);
    sample();
    check("t1_latency_grant", 32'(grant), 32'd0);
    check("t1_latency_s_cyc", 32'(s_if.cyc), 32'd0);
    step(); sample();
    check("t1_grant", 32'(grant), 32'd1);
    check("t1_s_cyc", 32'(s_if.cyc), 32'd1);
    check("t1_s_stb", 32'(s_if.stb), 32'd1);
    check("t1_s_we", 32'(s_if.we), 32'd1);
    check("t1_s_adr", s_if.adr, 32'h3001_0004);
    check("t1_s_dat", s_if.dat_w, 32'h1234_5678);
    check("t1_s_sel", 32'(s_if.sel), 32'hF);
    check("t1_m0_ack_c1", 32'(m0_if.ack), 32'd0);
    step(); sample();
    check("t1_m0_ack_c2", 32'(m0_if.ack), 32'd0);
    step();
    s_if.ack = 1'b1;
    sample();
    check("t1_m0_ack_c3", 32'(m0_if.ack), 32'd1);
    check("t1_m1_ack_c3", 32'(m1_if.ack), 32'd0);
    step();
    s_if.ack = 1'b0;
    m0_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    sample();
    check("t1_m0_ack_c4", 32'(m0_if.ack), 32'd0);
    check("t1_grant_hold", 32'(grant), 32'd1);
    step(); sample();
    check("t1_release", 32'(grant), 32'd0);

    // tie after reset, direct handoff, then alternation
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    m0_drive(1'b1, 1'b0, 32'h0000_00A0, 32'd0, 4'hF);
    m1_drive(1'b1, 1'b0, 32'h0000_00B0, 32'd0, 4'hF);
    step();
    s_if.ack = 1'b1; s_if.dat_r = 32'h1111_2222;
    sample();
    check("t2_tie_grant", 32'(grant), 32'd1);
    check("t2_tie_s_adr", s_if.adr, 32'h0000_00A0);
    check("t2_m0_dat", m0_if.dat_r, 32'h1111_2222);
    check("t2_m1_ack", 32'(m1_if.ack), 32'd0);
    check("t2_m1_dat", m1_if.dat_r, 32'd0);
    step();
    s_if.ack = 1'b0;
    m0_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    sample();
    check("t2_drop_grant", 32'(grant), 32'd1);
    step(); sample();
    check("t2_handoff_grant", 32'(grant), 32'd2);
    check("t2_handoff_s_adr", s_if.adr, 32'h0000_00B0);
    step();
    m1_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step(); sample();
    check("t2_idle", 32'(grant), 32'd0);
    m0_drive(1'b1, 1'b0, 32'h0000_00A4, 32'd0, 4'hF);
    m1_drive(1'b1, 1'b0, 32'h0000_00B4, 32'd0, 4'hF);
    step(); sample();
    check("t2_tie2_grant", 32'(grant), 32'd1);
    m0_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step(); sample();
    check("t2_handoff2_grant", 32'(grant), 32'd2);
    m1_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step(); sample();
    check("t2_idle2", 32'(grant), 32'd0);

    // m0 3-beat read burst while m1 waits
    m0_drive(1'b1, 1'b0, 32'h3000_0010, 32'd0, 4'hF);
    step();
    m1_drive(1'b1, 1'b0, 32'h3000_0020, 32'd0, 4'hF);
    s_if.ack = 1'b1; s_if.dat_r = 32'hA5A5_A5A5;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("t3_grant", 32'(grant), 32'd1);
      check("t3_m0_ack", 32'(m0_if.ack), 32'd1);
      check("t3_m0_dat", m0_if.dat_r, 32'hA5A5_A5A5);
      check("t3_m1_ack", 32'(m1_if.ack), 32'd0);
      check("t3_m1_dat", m1_if.dat_r, 32'd0);
      step();
    end
    s_if.ack = 1'b0;
    m0_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    sample();
    check("t3_lock_end_grant", 32'(grant), 32'd1);
    check("t3_lock_end_m1_ack", 32'(m1_if.ack), 32'd0);
    step(); sample();
    check("t3_m1_granted", 32'(grant), 32'd2);

    // reset pulse during the granted m1 read
    step(); rst = 1'b1;
    sample();
    check("t4_pre_rst_grant", 32'(grant), 32'd2);
    step();
    rst = 1'b0; s_if.ack = 1'b1; s_if.dat_r = 32'h7777_7777;
    sample();
    check("t4_rst_grant", 32'(grant), 32'd0);
    check("t4_rst_s_cyc", 32'(s_if.cyc), 32'd0);
    check("t4_rst_m1_ack", 32'(m1_if.ack), 32'd0);
    check("t4_rst_m1_dat", m1_if.dat_r, 32'd0);
    step();
    s_if.ack = 1'b0; s_if.dat_r = 32'd0;
    m1_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    step(); step();

`ifdef WB_ARB_TIMEOUT_EN
    // slave never answers: forced termination in the 8th strobe cycle
    m0_drive(1'b1, 1'b0, 32'h3000_0030, 32'd0, 4'hF);
    step();
    for (int i = 1; i < 8; i++) begin
      sample();
      check("t5_wait_ack", 32'(m0_if.ack), 32'd0);
      step();
    end
    sample();
    check("t5_to_ack", 32'(m0_if.ack), 32'd1);
    check("t5_to_dat", m0_if.dat_r, 32'hDEAD_BEEF);
    check("t5_to_s_stb", 32'(s_if.stb), 32'd0);
    check("t5_to_s_cyc", 32'(s_if.cyc), 32'd0);
    check("t5_to_cnt_before", 32'(tcnt), 32'd0);
    step();
    m0_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    sample();
    check("t5_to_cnt_after", 32'(tcnt), 32'd1);
    check("t5_after_ack", 32'(m0_if.ack), 32'd0);

    // slave answers exactly on the limit cycle: normal ack wins
    step();
    m0_drive(1'b1, 1'b0, 32'h3000_0034, 32'd0, 4'hF);
    step();
    for (int i = 1; i < 8; i++) begin
      sample();
      check("t6_wait_ack", 32'(m0_if.ack), 32'd0);
      step();
    end
    s_if.ack = 1'b1; s_if.dat_r = 32'h600D_F00D;
    sample();
    check("t6_ack", 32'(m0_if.ack), 32'd1);
    check("t6_dat", m0_if.dat_r, 32'h600D_F00D);
    check("t6_s_cyc", 32'(s_if.cyc), 32'd1);
    step();
    s_if.ack = 1'b0;
    m0_drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    sample();
    check("t6_cnt_unchanged", 32'(tcnt), 32'd1);
    step(); step();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
